// File: rtl/fetch_unit_pkg.sv
// Shared widths, state encoding and payload type for the fetch stage.
package fetch_unit_pkg;

    localparam int unsigned WORD        = 64;
    localparam int unsigned INSTR_LEN   = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [WORD-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
    } fetch_pkt_t;

    // A fetch address is unusable if misaligned or beyond the end of instruction memory.
    function automatic logic pc_is_bad(input logic [WORD-1:0] pc, input logic [WORD-1:0] limit);
        return (pc[1:0] != 2'b00) || (pc >= limit);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, instr} words; clear beats push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 96,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    // State registers; payload storage needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // The issue rule upstream guarantees a free slot for every returning word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !clear && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle instruction memory and buffers results.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC   = '0,
    parameter int unsigned     DEPTH      = 2,
    parameter logic [WORD-1:0] IMEM_BYTES = WORD'(4096)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [WORD-1:0]      imem_addr,
    input  logic [INSTR_LEN-1:0] imem_instr,
    input  logic                 redirect_valid,
    input  logic [WORD-1:0]      redirect_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] out_instr,
    output logic [WORD-1:0]      out_pc,
    output logic                 fault
);

    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PKW = $bits(fetch_pkt_t);

    fetch_state_e    state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            fault_q, fault_d;

    logic [CW-1:0]   fifo_count;
    logic [PKW-1:0]  fifo_rdata;
    fetch_pkt_t      push_pkt;
    fetch_pkt_t      head_pkt;
    logic [CW1-1:0]  occ;
    logic            pop, flush, push, try_issue, bad_pc, issue;

    assign imem_addr = pc_q;
    assign fault     = fault_q;
    assign out_valid = (fifo_count != '0);
    assign head_pkt  = fetch_pkt_t'(fifo_rdata);
    assign out_pc    = out_valid ? head_pkt.pc    : '0;
    assign out_instr = out_valid ? head_pkt.instr : '0;
    assign push_pkt  = '{pc: inflight_pc_q, instr: imem_instr};

    // Issue decision, redirect handling and RUN/FAULT transitions.
    always_comb begin
        pop       = out_valid && out_ready;
        flush     = (state_q == FETCH_RUN) && redirect_valid;
        push      = inflight_q && !flush;
        occ       = CW1'(fifo_count) + CW1'(inflight_q) - CW1'(pop);
        try_issue = (state_q == FETCH_RUN) && !redirect_valid && (occ < CW1'(DEPTH));
        bad_pc    = pc_is_bad(pc_q, IMEM_BYTES);
        issue     = try_issue && !bad_pc;

        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fault_d       = fault_q;

        if (flush) begin
            pc_d = redirect_target;
        end else if (issue) begin
            pc_d          = pc_q + WORD'(INSTR_BYTES);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end else if (try_issue && bad_pc) begin
            state_d = FETCH_FAULT;
            fault_d = 1'b1;
        end
    end

    // Registered fetch state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (PKW)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (PKW'(push_pkt)),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized ready/redirect run.
module tb_fetch_unit;

    localparam logic [63:0] IMEM_BYTES = 64'd4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;

    // Reference model: the next (pc) the decoder should see, and whether fetch has faulted.
    logic [63:0] exp_pc = 64'h0;
    bit          exp_fault = 1'b0;
    bit          prev_hold = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (64'h0),
        .DEPTH      (2),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fault           (fault)
    );

    // Instruction memory image: registered read, word at byte address A holds A/4.
    always @(posedge clk) imem_instr <= 32'(imem_addr >> 2);

    function automatic bit model_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (a >= IMEM_BYTES);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge and compare the output stream against the model.
    task automatic sample();
        @(negedge clk);
        if (reset) begin
            exp_pc    = 64'h0;
            exp_fault = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                chk("stream_in_range", 64'(model_bad(exp_pc)), 64'd0);
                chk("stream_pc", out_pc, exp_pc);
                chk("stream_instr", 64'(out_instr), exp_pc >> 2);
                if (out_ready) begin
                    hs_cnt++;
                    exp_pc = exp_pc + 64'd4;
                end
            end
            if (redirect_valid && !exp_fault) exp_pc = redirect_target;
            prev_hold = out_valid && !out_ready && !(redirect_valid && !exp_fault);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 64'h0;

        // Reset state
        repeat (2) tick();
        sample();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        adv();

        // First-instruction latency, then one per cycle
        reset = 1'b0; out_ready = 1'b1;
        sample(); chk("lat_c0_valid", 64'(out_valid), 64'd0); adv();
        sample(); chk("lat_c1_valid", 64'(out_valid), 64'd0); adv();
        sample();
        chk("lat_c2_valid", 64'(out_valid), 64'd1);
        chk("lat_c2_pc", out_pc, 64'd0);
        chk("lat_c2_instr", 64'(out_instr), 64'd0);
        adv();
        for (int i = 0; i < 6; i++) begin
            sample(); chk("run_valid", 64'(out_valid), 64'd1); adv();
        end

        // Stall: FIFO fills, PC stops two words past the head
        out_ready = 1'b0;
        repeat (5) tick();
        sample();
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_pc_frozen", imem_addr, exp_pc + 64'd8);
        adv();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(); chk("resume_nogap", 64'(out_valid), 64'd1); adv();
        end

        // Randomized ready and in-range redirects
        for (int i = 0; i < 300; i++) begin
            out_ready       = ($urandom_range(3) != 0);
            redirect_valid  = ($urandom_range(15) == 0);
            redirect_target = 64'($urandom_range(511)) << 2;
            tick();
        end
        redirect_valid = 1'b0;
        chk("random_progress", 64'(hs_cnt > 100), 64'd1);

        // Redirect to 0x100 while the FIFO is full
        out_ready = 1'b0;
        repeat (6) tick();
        redirect_valid = 1'b1; redirect_target = 64'h100;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        sample(); chk("redir_r1_valid", 64'(out_valid), 64'd0); adv();
        sample(); chk("redir_r2_valid", 64'(out_valid), 64'd0); adv();
        sample();
        chk("redir_r3_valid", 64'(out_valid), 64'd1);
        chk("redir_r3_pc", out_pc, 64'h100);
        chk("redir_r3_instr", 64'(out_instr), 64'h40);
        adv();
        sample();
        chk("redir_r4_pc", out_pc, 64'h104);
        chk("redir_r4_instr", 64'(out_instr), 64'h41);
        adv();
        repeat (4) tick();

        // Redirect to a misaligned target faults, stops issue, ignores redirects
        redirect_valid = 1'b1; redirect_target = 64'h102;
        tick();
        redirect_valid = 1'b0;
        tick();
        sample();
        chk("misalign_fault", 64'(fault), 64'd1);
        chk("misalign_addr", imem_addr, 64'h102);
        chk("misalign_valid", 64'(out_valid), 64'd0);
        adv();
        exp_fault = 1'b1;
        redirect_valid = 1'b1; redirect_target = 64'h200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("fault_sticky", 64'(fault), 64'd1);
            chk("fault_no_issue", imem_addr, 64'h102);
            chk("fault_no_valid", 64'(out_valid), 64'd0);
            adv();
        end

        // Reset leaves FAULT
        reset = 1'b1;
        sample(); adv();
        sample();
        chk("rst_exit_fault", 64'(fault), 64'd0);
        chk("rst_exit_addr", imem_addr, 64'd0);
        adv();
        reset = 1'b0; out_ready = 1'b0;
        repeat (4) tick();

        // Redirect to last word: it is buffered, then fault at IMEM_BYTES, then it drains
        redirect_valid = 1'b1; redirect_target = 64'hFFC;
        tick();
        redirect_valid = 1'b0;
        repeat (2) tick();
        sample();
        chk("end_fault", 64'(fault), 64'd1);
        chk("end_addr", imem_addr, IMEM_BYTES);
        chk("end_valid", 64'(out_valid), 64'd1);
        chk("end_pc", out_pc, 64'hFFC);
        chk("end_instr", 64'(out_instr), 64'h3FF);
        adv();
        exp_fault = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            sample(); chk("end_drained", 64'(out_valid), 64'd0); adv();
        end

        // Reset during a full stall
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        sample(); chk("pre_rst_full_valid", 64'(out_valid), 64'd1); adv();
        reset = 1'b1;
        sample(); adv();
        sample();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_fault", 64'(fault), 64'd0);
        adv();
        reset = 1'b0; out_ready = 1'b1;
        sample(); chk("restart_c0_valid", 64'(out_valid), 64'd0); adv();
        sample(); chk("restart_c1_valid", 64'(out_valid), 64'd0); adv();
        sample();
        chk("restart_c2_valid", 64'(out_valid), 64'd1);
        chk("restart_c2_pc", out_pc, 64'd0);
        chk("restart_c2_instr", 64'(out_instr), 64'd0);
        adv();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
